// File: rtl/ifq_fetch_queue.sv
// ifq_fetch_queue: icache line fetcher feeding a circular instruction queue; define IFQ_STATS_EN for flush/stall counters
module ifq_fetch_queue #(
   parameter int          DEPTH       = 16,
   parameter int          FETCH_WIDTH = 4,
   parameter logic [31:0] RESET_PC    = 32'h00400000
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      icache_req,
   output logic [31:0]               icache_addr,
   input  logic                      icache_ack,
   input  logic [32*FETCH_WIDTH-1:0] icache_data,
   output logic [31:0]               ifq_icode,
   output logic [31:0]               ifq_pc,
   output logic                      ifq_empty,
   input  logic                      dispatch_rd,
   input  logic [31:0]               jump_branch_add,
   input  logic                      jump_branch_valid
`ifdef IFQ_STATS_EN
   ,
   output logic [15:0]               flush_cnt,
   output logic [15:0]               stall_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int LB = $clog2(FETCH_WIDTH) + 2;
   localparam logic [AW:0] FW_C = (AW+1)'(FETCH_WIDTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [31:0] LINE_MASK = ~((32'd1 << LB) - 32'd1);
   typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;
   state_t        state_q, state_d;
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [AW:0]   count_q, count_d, n;
   logic [31:0]   fetch_pc_q, fetch_pc_d, addr_q, addr_d, line_base, off;
   logic          req_q, req_d, push, pop;
   logic [31:0]   mem_icode_q [DEPTH];
   logic [31:0]   mem_icode_d [DEPTH];
   logic [31:0]   mem_pc_q [DEPTH];
   logic [31:0]   mem_pc_d [DEPTH];
   assign line_base   = fetch_pc_q & LINE_MASK;
   assign off         = (fetch_pc_q >> 2) & 32'(FETCH_WIDTH - 1);
   assign n           = FW_C - (AW+1)'(off);
   assign push        = state_q == REQ && icache_ack && !jump_branch_valid;
   assign pop         = dispatch_rd && count_q != '0 && !jump_branch_valid;
   assign ifq_empty   = count_q == '0;
   assign ifq_icode   = ifq_empty ? 32'h00000013 : mem_icode_q[head_q];
   assign ifq_pc      = ifq_empty ? 32'h0 : mem_pc_q[head_q];
   assign icache_req  = req_q;
   assign icache_addr = addr_q;
   // queue pointers and fetch PC; a flush wins over push and pop
   always_comb begin
      head_d     = jump_branch_valid ? '0 : head_q + AW'(pop);
      tail_d     = jump_branch_valid ? '0 : push ? tail_q + n[AW-1:0] : tail_q;
      count_d    = jump_branch_valid ? '0 : count_q + (push ? n : '0) - (AW+1)'(pop);
      fetch_pc_d = jump_branch_valid ? jump_branch_add & 32'hFFFFFFFC :
                   push ? line_base + 32'(4*FETCH_WIDTH) : fetch_pc_q;
   end
   // request FSM; icache_addr only moves when a new request is launched
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      if (state_q == IDLE) begin
         if (!jump_branch_valid && DEPTH_C - count_q >= FW_C) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = line_base;
         end
      end else if (state_q == REQ) begin
         if (jump_branch_valid) begin
            state_d = icache_ack ? IDLE : KILL;
            req_d   = !icache_ack;
         end else if (icache_ack) begin
            state_d = DEPTH_C - count_d >= FW_C ? REQ : IDLE;
            req_d   = DEPTH_C - count_d >= FW_C;
            addr_d  = fetch_pc_d & LINE_MASK;
         end
      end else if (icache_ack) begin
         state_d = IDLE;
         req_d   = 1'b0;
      end
   end
   // enqueue words offset..FETCH_WIDTH-1 of an accepted line at tail
   always_comb begin
      mem_icode_d = mem_icode_q;
      mem_pc_d    = mem_pc_q;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (push && 32'(i) >= off) begin
            mem_icode_d[tail_q + AW'(32'(i) - off)] = icache_data[32*i +: 32];
            mem_pc_d[tail_q + AW'(32'(i) - off)]    = line_base + 32'(4*i);
         end
      end
   end
   // control state with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC & LINE_MASK;
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end
   // queue storage needs no reset; count gates every read
   always_ff @(posedge clk) begin
      mem_icode_q <= mem_icode_d;
      mem_pc_q    <= mem_pc_d;
   end
`ifdef IFQ_STATS_EN
   logic [15:0] flush_cnt_q, flush_cnt_d, stall_cnt_q, stall_cnt_d;
   assign flush_cnt = flush_cnt_q;
   assign stall_cnt = stall_cnt_q;
   // saturating event counters
   always_comb begin
      flush_cnt_d = flush_cnt_q + 16'(jump_branch_valid && flush_cnt_q != 16'hFFFF);
      stall_cnt_d = stall_cnt_q + 16'(ifq_empty && !jump_branch_valid && stall_cnt_q != 16'hFFFF);
   end
   // counter registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
`endif
endmodule

// File: tb/tb_ifq_fetch_queue.sv
// tb_ifq_fetch_queue: directed bench for ifq_fetch_queue (DEPTH=16, FETCH_WIDTH=4)
module tb_ifq_fetch_queue;
   logic         clk = 1'b0, rst = 1'b0, icache_ack = 1'b0, dispatch_rd = 1'b0, jump_branch_valid = 1'b0;
   logic [127:0] icache_data = '0;
   logic [31:0]  jump_branch_add = '0;
   logic         icache_req, ifq_empty;
   logic [31:0]  icache_addr, ifq_icode, ifq_pc;
   int           total = 0, bad = 0;
`ifdef IFQ_STATS_EN
   logic [15:0]  flush_cnt, stall_cnt;
`endif

   ifq_fetch_queue dut (
      .clk(clk), .rst(rst), .icache_req(icache_req), .icache_addr(icache_addr),
      .icache_ack(icache_ack), .icache_data(icache_data), .ifq_icode(ifq_icode),
      .ifq_pc(ifq_pc), .ifq_empty(ifq_empty), .dispatch_rd(dispatch_rd),
      .jump_branch_add(jump_branch_add), .jump_branch_valid(jump_branch_valid)
`ifdef IFQ_STATS_EN
      , .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return pc ^ 32'hA5C30000;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_ack(input logic [31:0] base);
      for (int i = 0; i < 4; i++) icache_data[32*i +: 32] = word_of(base + 32'(4*i));
      icache_ack = 1'b1;
      tick;
      icache_ack = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      int n = 0;
      while (icache_req !== 1'b1 && n < 20) begin
         tick;
         n++;
      end
      ok = icache_req === 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick;
      tick;
      total++; if (ifq_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", ifq_empty); end
      total++; if (icache_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", icache_req); end
      total++; if (ifq_icode !== 32'h13) begin bad++; $display("FAIL reset_icode got=%h want=00000013", ifq_icode); end
      total++; if (ifq_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", ifq_pc); end
      rst = 1'b1;
      total++; if (icache_req !== 1'b0) begin bad++; $display("FAIL req_after_e0 got=%b want=0", icache_req); end
      tick;
      total++; if (icache_req !== 1'b1 || icache_addr !== 32'h00400000) begin bad++; $display("FAIL req_after_e1 got=%b/%h want=1/00400000", icache_req, icache_addr); end
   endtask

   task automatic test_basic;
      send_ack(32'h00400000);
      total++; if (ifq_empty !== 1'b0) begin bad++; $display("FAIL basic_nonempty got=%b want=0", ifq_empty); end
      for (int i = 0; i < 4; i++) begin
         total++; if (ifq_pc !== 32'h00400000 + 32'(4*i) || ifq_icode !== word_of(32'h00400000 + 32'(4*i))) begin
            bad++; $display("FAIL basic_head%0d got=%h/%h want=%h/%h", i, ifq_pc, ifq_icode, 32'h00400000 + 32'(4*i), word_of(32'h00400000 + 32'(4*i)));
         end
         dispatch_rd = 1'b1;
         tick;
         dispatch_rd = 1'b0;
      end
      total++; if (ifq_empty !== 1'b1 || ifq_icode !== 32'h13) begin bad++; $display("FAIL basic_drained got=%b/%h want=1/00000013", ifq_empty, ifq_icode); end
      total++; if (icache_req !== 1'b1 || icache_addr !== 32'h00400010) begin bad++; $display("FAIL basic_next_req got=%b/%h want=1/00400010", icache_req, icache_addr); end
   endtask

   task automatic test_fill;
      bit ok, seen;
      dispatch_rd = 1'b1;
      tick;
      dispatch_rd = 1'b0;
      for (int l = 0; l < 4; l++) begin
         wait_req(ok);
         total++; if (!ok || icache_addr !== 32'h00400010 + 32'(16*l)) begin bad++; $display("FAIL fill_req%0d got=%b/%h want=1/%h", l, ok, icache_addr, 32'h00400010 + 32'(16*l)); end
         send_ack(32'h00400010 + 32'(16*l));
      end
      seen = icache_req;
      repeat (3) begin
         tick;
         seen = seen | icache_req;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL fill_full_req got=%b want=0", seen); end
      total++; if (ifq_pc !== 32'h00400010) begin bad++; $display("FAIL fill_head got=%h want=00400010", ifq_pc); end
      dispatch_rd = 1'b1;
      tick;
      dispatch_rd = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         tick;
         seen = seen | icache_req;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL fill_one_pop_req got=%b want=0", seen); end
      for (int i = 1; i < 4; i++) begin
         total++; if (ifq_pc !== 32'h00400010 + 32'(4*i)) begin bad++; $display("FAIL fill_pop%0d got=%h want=%h", i, ifq_pc, 32'h00400010 + 32'(4*i)); end
         dispatch_rd = 1'b1;
         tick;
         dispatch_rd = 1'b0;
      end
      tick;
      total++; if (icache_req !== 1'b1 || icache_addr !== 32'h00400050) begin bad++; $display("FAIL fill_four_pop_req got=%b/%h want=1/00400050", icache_req, icache_addr); end
      send_ack(32'h00400050);
      total++; if (icache_req !== 1'b0) begin bad++; $display("FAIL fill_refull_req got=%b want=0", icache_req); end
   endtask

   task automatic test_flush_idle;
      jump_branch_add = 32'h00400018;
      jump_branch_valid = 1'b1;
      tick;
      jump_branch_valid = 1'b0;
      total++; if (ifq_empty !== 1'b1 || icache_req !== 1'b0) begin bad++; $display("FAIL fidle_k1 got=%b/%b want=1/0", ifq_empty, icache_req); end
      tick;
      total++; if (icache_req !== 1'b1 || icache_addr !== 32'h00400010) begin bad++; $display("FAIL fidle_k2_req got=%b/%h want=1/00400010", icache_req, icache_addr); end
      send_ack(32'h00400010);
      total++; if (ifq_pc !== 32'h00400018 || ifq_icode !== word_of(32'h00400018)) begin bad++; $display("FAIL fidle_w2 got=%h/%h want=00400018/%h", ifq_pc, ifq_icode, word_of(32'h00400018)); end
      dispatch_rd = 1'b1;
      tick;
      dispatch_rd = 1'b0;
      total++; if (ifq_pc !== 32'h0040001C || ifq_icode !== word_of(32'h0040001C)) begin bad++; $display("FAIL fidle_w3 got=%h/%h want=0040001c/%h", ifq_pc, ifq_icode, word_of(32'h0040001C)); end
      dispatch_rd = 1'b1;
      tick;
      dispatch_rd = 1'b0;
      total++; if (ifq_empty !== 1'b1) begin bad++; $display("FAIL fidle_only2 got=%b want=1", ifq_empty); end
      total++; if (icache_req !== 1'b1 || icache_addr !== 32'h00400020) begin bad++; $display("FAIL fidle_next got=%b/%h want=1/00400020", icache_req, icache_addr); end
   endtask

   task automatic test_flush_req;
      jump_branch_add = 32'h00400106;
      jump_branch_valid = 1'b1;
      tick;
      jump_branch_valid = 1'b0;
      total++; if (ifq_empty !== 1'b1 || icache_req !== 1'b1 || icache_addr !== 32'h00400020) begin bad++; $display("FAIL kill_hold got=%b/%b/%h want=1/1/00400020", ifq_empty, icache_req, icache_addr); end
      tick;
      tick;
      send_ack(32'h00400020);
      total++; if (ifq_empty !== 1'b1 || icache_req !== 1'b0) begin bad++; $display("FAIL kill_discard got=%b/%b want=1/0", ifq_empty, icache_req); end
      tick;
      total++; if (icache_req !== 1'b1 || icache_addr !== 32'h00400100) begin bad++; $display("FAIL kill_redirect got=%b/%h want=1/00400100", icache_req, icache_addr); end
      send_ack(32'h00400100);
      total++; if (ifq_pc !== 32'h00400104 || ifq_icode !== word_of(32'h00400104)) begin bad++; $display("FAIL kill_target got=%h/%h want=00400104/%h", ifq_pc, ifq_icode, word_of(32'h00400104)); end
      jump_branch_add = 32'h00400200;
      jump_branch_valid = 1'b1;
      dispatch_rd = 1'b1;
      for (int i = 0; i < 4; i++) icache_data[32*i +: 32] = word_of(32'h00400110 + 32'(4*i));
      icache_ack = 1'b1;
      tick;
      icache_ack = 1'b0;
      dispatch_rd = 1'b0;
      jump_branch_valid = 1'b0;
      total++; if (ifq_empty !== 1'b1 || icache_req !== 1'b0) begin bad++; $display("FAIL flush_ack_same got=%b/%b want=1/0", ifq_empty, icache_req); end
      tick;
      total++; if (icache_req !== 1'b1 || icache_addr !== 32'h00400200) begin bad++; $display("FAIL flush_ack_redirect got=%b/%h want=1/00400200", icache_req, icache_addr); end
   endtask

   task automatic test_back_to_back;
      bit ok;
      send_ack(32'h00400200);
      wait_req(ok);
      total++; if (!ok || icache_addr !== 32'h00400210) begin bad++; $display("FAIL b2b_req210 got=%b/%h want=1/00400210", ok, icache_addr); end
      send_ack(32'h00400210);
      for (int i = 0; i < 3; i++) begin
         dispatch_rd = 1'b1;
         tick;
         dispatch_rd = 1'b0;
      end
      total++; if (ifq_pc !== 32'h0040020C || icache_req !== 1'b1 || icache_addr !== 32'h00400220) begin bad++; $display("FAIL b2b_pre got=%h/%b/%h want=0040020c/1/00400220", ifq_pc, icache_req, icache_addr); end
      dispatch_rd = 1'b1;
      send_ack(32'h00400220);
      dispatch_rd = 1'b0;
      total++; if (icache_req !== 1'b1 || icache_addr !== 32'h00400230) begin bad++; $display("FAIL b2b_req230 got=%b/%h want=1/00400230", icache_req, icache_addr); end
      send_ack(32'h00400230);
      total++; if (icache_req !== 1'b1 || icache_addr !== 32'h00400240) begin bad++; $display("FAIL b2b_req240 got=%b/%h want=1/00400240", icache_req, icache_addr); end
      send_ack(32'h00400240);
      total++; if (icache_req !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b want=0", icache_req); end
      for (int i = 0; i < 16; i++) begin
         total++; if (ifq_pc !== 32'h00400210 + 32'(4*i) || ifq_icode !== word_of(32'h00400210 + 32'(4*i))) begin
            bad++; $display("FAIL b2b_order%0d got=%h/%h want=%h/%h", i, ifq_pc, ifq_icode, 32'h00400210 + 32'(4*i), word_of(32'h00400210 + 32'(4*i)));
         end
         dispatch_rd = 1'b1;
         tick;
         dispatch_rd = 1'b0;
      end
      total++; if (ifq_empty !== 1'b1) begin bad++; $display("FAIL b2b_drained got=%b want=1", ifq_empty); end
   endtask

   task automatic test_reset_kill;
      jump_branch_add = 32'h00400300;
      jump_branch_valid = 1'b1;
      tick;
      jump_branch_valid = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) icache_data[32*i +: 32] = word_of(32'h00400250 + 32'(4*i));
      icache_ack = 1'b1;
      tick;
      icache_ack = 1'b0;
      total++; if (ifq_empty !== 1'b1 || icache_req !== 1'b0) begin bad++; $display("FAIL rkill_reset got=%b/%b want=1/0", ifq_empty, icache_req); end
      rst = 1'b1;
      tick;
      total++; if (icache_req !== 1'b1 || icache_addr !== 32'h00400000) begin bad++; $display("FAIL rkill_restart got=%b/%h want=1/00400000", icache_req, icache_addr); end
      send_ack(32'h00400000);
      total++; if (ifq_pc !== 32'h00400000 || ifq_icode !== word_of(32'h00400000)) begin bad++; $display("FAIL rkill_fetch got=%h/%h want=00400000/%h", ifq_pc, ifq_icode, word_of(32'h00400000)); end
   endtask

`ifdef IFQ_STATS_EN
   task automatic test_stats;
      rst = 1'b0;
      tick;
      total++; if (flush_cnt !== 16'd0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL stats_reset got=%0d/%0d want=0/0", flush_cnt, stall_cnt); end
      rst = 1'b1;
      repeat (3) tick;
      jump_branch_add = 32'h00400040;
      jump_branch_valid = 1'b1;
      tick;
      tick;
      jump_branch_valid = 1'b0;
      repeat (4) tick;
      total++; if (flush_cnt !== 16'd2 || stall_cnt !== 16'd7) begin bad++; $display("FAIL stats_count got=%0d/%0d want=2/7", flush_cnt, stall_cnt); end
      rst = 1'b0;
      tick;
      total++; if (flush_cnt !== 16'd0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL stats_clear got=%0d/%0d want=0/0", flush_cnt, stall_cnt); end
      rst = 1'b1;
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_fill;
      test_flush_idle;
      test_flush_req;
      test_back_to_back;
      test_reset_kill;
`ifdef IFQ_STATS_EN
      test_stats;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
